// File: rtl/ifexp_pkg.sv
// Shared types and helpers for the IfExp window reducer.
// The result-struct macro lets each module size the struct from its own NX/WINDOW.
`define IFEXP_RESULT_T(nx, sw, cw) struct packed { logic [(sw)-1:0] sum; logic [(nx)-1:0] max; logic [(nx)-1:0] min; logic [(cw)-1:0] cnt; }
`define IFEXP_MAX(a, b) (((a) > (b)) ? (a) : (b))
`define IFEXP_MIN(a, b) (((a) < (b)) ? (a) : (b))

package ifexp_pkg;
  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_e;

  localparam int unsigned NX_DEFAULT     = 8;
  localparam int unsigned WINDOW_DEFAULT = 4;
  localparam int unsigned CW_DEFAULT     = $clog2(WINDOW_DEFAULT + 1);
  localparam int unsigned SW_DEFAULT     = NX_DEFAULT + CW_DEFAULT;

  typedef `IFEXP_RESULT_T(NX_DEFAULT, SW_DEFAULT, CW_DEFAULT) result_t;
endpackage

// File: rtl/ifexp_reduce_acc.sv
// Combinational next-value logic for the window accumulator (sum/max/min/cnt).
module ifexp_reduce_acc #(
  parameter  int unsigned NX     = 8,
  parameter  int unsigned WINDOW = 4,
  localparam int unsigned CW     = $clog2(WINDOW + 1),
  localparam int unsigned SW     = NX + CW
) (
  input  logic [SW-1:0] i_sum,
  input  logic [NX-1:0] i_max,
  input  logic [NX-1:0] i_min,
  input  logic [CW-1:0] i_cnt,
  input  logic [NX-1:0] i_data,
  output logic [SW-1:0] o_sum,
  output logic [NX-1:0] o_max,
  output logic [NX-1:0] o_min,
  output logic [CW-1:0] o_cnt
);
  logic w_first;

  assign w_first = (i_cnt == '0);

  always_comb begin
    o_sum = i_sum + SW'(i_data);
    o_max = `IFEXP_MAX(i_data, i_max);
    o_min = `IFEXP_MIN(i_data, i_min);
    o_cnt = i_cnt + CW'(1);
    // First sample of a window seeds every field directly.
    if (w_first) begin
      o_sum = SW'(i_data);
      o_max = i_data;
      o_min = i_data;
    end
  end
endmodule

// File: rtl/ifexp_window_reduce.sv
// Reduces windows of accepted IfExp samples into sum/max/min/count results.
// Handshake: a transfer happens on a rising edge where VALID && READY are both high.
module ifexp_window_reduce
  import ifexp_pkg::*;
#(
  parameter  int unsigned NX     = 8,
  parameter  int unsigned WINDOW = 4,
  localparam int unsigned CW     = $clog2(WINDOW + 1),
  localparam int unsigned SW     = NX + CW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [NX-1:0] IN_DATA,
  input  logic          FLUSH,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [SW-1:0] OUT_SUM,
  output logic [NX-1:0] OUT_MAX,
  output logic [NX-1:0] OUT_MIN,
  output logic [CW-1:0] OUT_CNT,
  output state_e        o_dbg_state
);
  typedef `IFEXP_RESULT_T(NX, SW, CW) red_t;

  localparam red_t ACC_CLEAR = {SW'(0), NX'(0), {NX{1'b1}}, CW'(0)};

  state_e        r_state;
  state_e        w_state_nxt;
  red_t          r_acc;
  red_t          r_out;
  red_t          w_step;
  red_t          w_upd;
  logic          w_accept;
  logic          w_consume;
  logic          w_close;
  logic [SW-1:0] w_step_sum;
  logic [NX-1:0] w_step_max;
  logic [NX-1:0] w_step_min;
  logic [CW-1:0] w_step_cnt;

  ifexp_reduce_acc #(.NX(NX), .WINDOW(WINDOW)) u_acc (
    .i_sum  (r_acc.sum),
    .i_max  (r_acc.max),
    .i_min  (r_acc.min),
    .i_cnt  (r_acc.cnt),
    .i_data (IN_DATA),
    .o_sum  (w_step_sum),
    .o_max  (w_step_max),
    .o_min  (w_step_min),
    .o_cnt  (w_step_cnt)
  );

  always_comb begin
    w_step      = {w_step_sum, w_step_max, w_step_min, w_step_cnt};
    // While EMIT, a sample is only taken when the pending result leaves the same cycle.
    IN_READY    = (r_state == ACCUM) || OUT_READY;
    OUT_VALID   = (r_state == EMIT);
    w_accept    = IN_VALID && IN_READY;
    w_consume   = OUT_VALID && OUT_READY;
    w_upd       = w_accept ? w_step : r_acc;
    w_close     = (w_accept && (w_upd.cnt == CW'(WINDOW))) || (FLUSH && (w_upd.cnt != '0));
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_close) w_state_nxt = EMIT;
      EMIT:    if (w_consume && !w_close) w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ACCUM;
      r_acc   <= ACC_CLEAR;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_close) begin
        r_acc <= ACC_CLEAR;
        r_out <= w_upd;
      end else begin
        r_acc <= w_upd;
      end
    end
  end

  assign OUT_SUM     = r_out.sum;
  assign OUT_MAX     = r_out.max;
  assign OUT_MIN     = r_out.min;
  assign OUT_CNT     = r_out.cnt;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_ifexp_window_reduce.sv
// Scoreboard bench for ifexp_window_reduce: directed windows plus a long randomized run.
module tb_ifexp_window_reduce;
  import ifexp_pkg::*;

  localparam int NX     = 8;
  localparam int WINDOW = 4;
  localparam int CW     = 3;
  localparam int SW     = 11;
  localparam int W      = SW + 2 * NX + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b1;
  logic [NX-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [SW-1:0] out_sum;
  logic [NX-1:0] out_max;
  logic [NX-1:0] out_min;
  logic [CW-1:0] out_cnt;
  state_e        dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit use_model = 1'b0;
  int m_sum, m_max, m_min, m_cnt, n_accept;
  bit m_emit = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ifexp_window_reduce #(.NX(NX), .WINDOW(WINDOW)) dut (
    .CLK         (clk),
    .RST         (rst),
    .IN_VALID    (in_valid),
    .IN_READY    (in_ready),
    .IN_DATA     (in_data),
    .FLUSH       (flush),
    .OUT_VALID   (out_valid),
    .OUT_READY   (out_ready),
    .OUT_SUM     (out_sum),
    .OUT_MAX     (out_max),
    .OUT_MIN     (out_min),
    .OUT_CNT     (out_cnt),
    .o_dbg_state (dbg_state)
  );

  function automatic logic [W-1:0] pack(input int s, input int mx, input int mn, input int c);
    return {SW'(s), NX'(mx), NX'(mn), CW'(c)};
  endfunction

  function automatic void model_clear();
    m_sum = 0;
    m_max = 0;
    m_min = 255;
    m_cnt = 0;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int s, input int mx, input int mn, input int c);
    exp_q.push_back(pack(s, mx, mn, c));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    m_emit = 1'b0;
    model_clear();
  endtask

  // ---------------- driver: one clock per call ----------------
  task automatic step(input logic v, input logic [NX-1:0] d, input logic f);
    logic exp_ready, acc, cons, close;
    in_valid = v;
    in_data  = d;
    flush    = f;
    @(negedge clk);
    check_bit("out_valid", out_valid, m_emit);
    exp_ready = !m_emit || out_ready;
    check_bit("in_ready", in_ready, exp_ready);
    acc  = v && exp_ready;
    cons = m_emit && out_ready;
    if (cons) m_emit = 1'b0;
    if (acc) begin
      if (m_cnt == 0) begin
        m_sum = int'(d);
        m_max = int'(d);
        m_min = int'(d);
      end else begin
        m_sum += int'(d);
        if (int'(d) > m_max) m_max = int'(d);
        if (int'(d) < m_min) m_min = int'(d);
      end
      m_cnt++;
      n_accept++;
    end
    close = (acc && m_cnt == WINDOW) || (f && m_cnt > 0);
    if (close) begin
      if (use_model) push_exp(m_sum, m_max, m_min, m_cnt);
      m_emit = 1'b1;
      model_clear();
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got sum=%0d max=%0d min=%0d cnt=%0d, expected no result at %0t",
                 out_sum, out_max, out_min, out_cnt, $time);
      end else begin
        e = exp_q[0];
        if ({out_sum, out_max, out_min, out_cnt} !== e) begin
          errors++;
          $display("FAIL result: got sum=%0d max=%0d min=%0d cnt=%0d, expected sum=%0d max=%0d min=%0d cnt=%0d at %0t",
                   out_sum, out_max, out_min, out_cnt,
                   e[W-1 -: SW], e[2*NX+CW-1 -: NX], e[NX+CW-1 -: NX], e[CW-1:0], $time);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    n_accept = 0;
    do_reset(2);
    @(negedge clk);
    checks++;
    if ({out_sum, out_max, out_min, out_cnt} !== '0 || dbg_state !== ACCUM) begin
      errors++;
      $display("FAIL reset_values: got sum=%0d max=%0d min=%0d cnt=%0d state=%0d, expected zeros and ACCUM",
               out_sum, out_max, out_min, out_cnt, dbg_state);
    end
    @(posedge clk);
    #1;

    // full window, sink always ready
    out_ready = 1'b1;
    push_exp(468, 255, 3, 4);
    step(1'b1, 8'd10, 1'b0);
    step(1'b1, 8'd200, 1'b0);
    step(1'b1, 8'd3, 1'b0);
    step(1'b1, 8'd255, 1'b0);
    idle(2);

    // stalled sink, then consume and accept in the same cycle
    push_exp(10, 4, 1, 4);
    step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd2, 1'b0);
    step(1'b1, 8'd3, 1'b0);
    out_ready = 1'b0;
    step(1'b1, 8'd4, 1'b0);
    idle(5);
    out_ready = 1'b1;
    step(1'b1, 8'd50, 1'b0);
    push_exp(50, 50, 50, 1);
    step(1'b0, '0, 1'b1);
    idle(2);

    // flush alone, then flush on an empty accumulator
    push_exp(16, 9, 7, 2);
    step(1'b1, 8'd7, 1'b0);
    step(1'b1, 8'd9, 1'b0);
    step(1'b0, '0, 1'b1);
    idle(2);
    step(1'b0, '0, 1'b1);
    idle(2);

    // flush together with an accepted sample
    push_exp(19, 8, 5, 3);
    step(1'b1, 8'd8, 1'b0);
    step(1'b1, 8'd6, 1'b0);
    step(1'b1, 8'd5, 1'b1);
    idle(2);

    // reset discards a partial window
    step(1'b1, 8'd100, 1'b0);
    step(1'b1, 8'd100, 1'b0);
    do_reset(1);
    push_exp(4, 1, 1, 4);
    repeat (4) step(1'b1, 8'd1, 1'b0);
    idle(2);

    // all-ones corner window
    push_exp(1020, 255, 255, 4);
    repeat (4) step(1'b1, 8'd255, 1'b0);
    idle(2);

    // randomized traffic checked against the model
    use_model = 1'b1;
    n_accept = 0;
    for (int c = 0; c < 20000 && n_accept < 2000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0));
    end
    checks++;
    if (n_accept < 2000) begin
      errors++;
      $display("FAIL random_budget: got %0d accepted samples, expected 2000", n_accept);
    end
    out_ready = 1'b1;
    step(1'b0, '0, 1'b1);
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results still pending, expected 0", exp_q.size());
    end
    check_bit("final_out_valid", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
